// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Owner encoding is shared by the round-robin pointer and the read-return tag.
package imem_arb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } owner_t;

endpackage

// File: rtl/imem_arb_rr_arb2.sv
// Two-way round-robin grant generator; `last_q` remembers the previous winner.
// f_en_i masks the fetch side entirely, so the loader alone is served while it is low.
module rr_arb2
    import imem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic f_en_i,
    input  logic f_req_i,
    input  logic l_req_i,
    output logic f_gnt_o,
    output logic l_gnt_o
);

    owner_t last_q;
    owner_t last_d;
    logic   f_req_m;

    assign f_req_m = f_req_i & f_en_i;

    // On contention the side that did not win last time is served.
    assign f_gnt_o = f_req_m & (~l_req_i | (last_q == OWN_LOADER));
    assign l_gnt_o = l_req_i & (~f_req_m | (last_q == OWN_FETCH));

    always_comb begin
        last_d = last_q;
        if (f_gnt_o) begin
            last_d = OWN_FETCH;
        end else if (l_gnt_o) begin
            last_d = OWN_LOADER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_LOADER;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/imem_arb.sv
// Instruction-memory port arbiter and boot sequencer: BOOT serves only the loader,
// RUN round-robins fetch and loader onto one synchronous single-port RAM.
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter bit BOOT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    input  logic          l_done,
    output logic          cpu_run,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam state_t ST_RST = BOOT_EN ? ST_BOOT : ST_RUN;

    state_t state_q;
    state_t state_d;
    logic   rsel_vld_q;
    logic   rsel_vld_d;
    owner_t rsel_own_q;
    owner_t rsel_own_d;

    // Byte-offset and out-of-range address bits are don't-care; words wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:AW+2], f_addr[1:0], l_addr[31:AW+2], l_addr[1:0]};

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (clrn),
        .f_en_i  (state_q == ST_RUN),
        .f_req_i (f_req),
        .l_req_i (l_req),
        .f_gnt_o (f_gnt),
        .l_gnt_o (l_gnt)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT && l_done) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (f_gnt) begin
            m_en   = 1'b1;
            m_addr = f_addr[AW+1:2];
        end else if (l_gnt) begin
            m_en    = 1'b1;
            m_we    = l_we;
            m_addr  = l_addr[AW+1:2];
            m_wdata = l_wdata;
        end
    end

    always_comb begin
        rsel_vld_d = f_gnt | (l_gnt & ~l_we);
        rsel_own_d = f_gnt ? OWN_FETCH : OWN_LOADER;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_RST;
            rsel_vld_q <= 1'b0;
            rsel_own_q <= OWN_FETCH;
        end else begin
            state_q    <= state_d;
            rsel_vld_q <= rsel_vld_d;
            rsel_own_q <= rsel_own_d;
        end
    end

    assign cpu_run  = (state_q == ST_RUN);
    assign f_rvalid = rsel_vld_q & (rsel_own_q == OWN_FETCH);
    assign l_rvalid = rsel_vld_q & (rsel_own_q == OWN_LOADER);
    assign f_rdata  = f_rvalid ? m_rdata : '0;
    assign l_rdata  = l_rvalid ? m_rdata : '0;

endmodule
